// File: rtl/atomrvcore_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : atomrvcore_hazard_ctrl
//  Brief    : Hazard controller for the atomRVCORE five-stage pipeline.
//             Generates ALU forwarding selects, load-use stalls, memory-wait
//             freezes and post-redirect decode flushes, and keeps saturating
//             stall / redirect performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module atomrvcore_hazard_ctrl #(
   parameter int REG_ADRESS_WIDTH = 5,
   parameter int FLUSH_CYCLES     = 2,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RS1_d_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RS2_d_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RS1_e_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RS2_e_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RD_e_i,
   input  logic                        RWR_EN_e_i,
   input  logic                        DR_EN_e_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RD_m_i,
   input  logic                        RWR_EN_m_i,
   input  logic [REG_ADRESS_WIDTH-1:0] RD_wb_i,
   input  logic                        RWR_EN_wb_i,
   input  logic                        redirect_i,
   input  logic                        mem_busy_i,
   output logic [1:0]                  fwd1_o,
   output logic [1:0]                  fwd2_o,
   output logic                        stall_f_o,
   output logic                        stall_d_o,
   output logic                        stall_e_o,
   output logic                        stall_m_o,
   output logic                        bubble_e_o,
   output logic                        flush_d_o,
   output logic [1:0]                  state_o,
   output logic [CNT_WIDTH-1:0]        stall_cycles_o,
   output logic [CNT_WIDTH-1:0]        redirect_count_o
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   // Remaining wrong-path slots after the redirect cycle itself.
   localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [REG_ADRESS_WIDTH-1:0] REG_X0 = '0;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;
   logic [CNT_WIDTH-1:0]  redir_cnt_q;

   logic                  load_use;
   logic                  redir_take;
   logic                  redir_merged;

   assign load_use = DR_EN_e_i && RWR_EN_e_i && (RD_e_i != REG_X0) &&
                     ((RD_e_i == RS1_d_i) || (RD_e_i == RS2_d_i));

   // A redirect deferred by a memory wait merges with a fresh one.
   assign redir_merged = pend_q | redirect_i;

   // Operand forwarding: memory stage beats writeback, x0 never forwards.
   always_comb begin
      fwd1_o = 2'b00;
      fwd2_o = 2'b00;
      if (!rst_i) begin
         if (RWR_EN_m_i && (RD_m_i != REG_X0) && (RD_m_i == RS1_e_i))
            fwd1_o = 2'b01;
         else if (RWR_EN_wb_i && (RD_wb_i != REG_X0) && (RD_wb_i == RS1_e_i))
            fwd1_o = 2'b10;
         if (RWR_EN_m_i && (RD_m_i != REG_X0) && (RD_m_i == RS2_e_i))
            fwd2_o = 2'b01;
         else if (RWR_EN_wb_i && (RD_wb_i != REG_X0) && (RD_wb_i == RS2_e_i))
            fwd2_o = 2'b10;
      end
   end

   // Next-state and control outputs for the sequencing FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      stall_f_o  = 1'b0;
      stall_d_o  = 1'b0;
      stall_e_o  = 1'b0;
      stall_m_o  = 1'b0;
      bubble_e_o = 1'b0;
      flush_d_o  = 1'b0;
      redir_take = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_busy_i) begin
               {stall_f_o, stall_d_o, stall_e_o, stall_m_o} = 4'b1111;
               pend_d  = redirect_i;
               state_d = ST_MEM_WAIT;
            end else if (redirect_i) begin
               flush_d_o  = 1'b1;
               bubble_e_o = 1'b1;
               redir_take = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_FLUSH;
                  cnt_d   = CNT_RELOAD;
               end
            end else if (load_use) begin
               stall_f_o  = 1'b1;
               stall_d_o  = 1'b1;
               bubble_e_o = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            if (mem_busy_i) begin
               {stall_f_o, stall_d_o, stall_e_o, stall_m_o} = 4'b1111;
               pend_d = redir_merged;
            end else begin
               pend_d  = 1'b0;
               state_d = ST_RUN;
               if (redir_merged) begin
                  flush_d_o  = 1'b1;
                  bubble_e_o = 1'b1;
                  redir_take = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = ST_FLUSH;
                     cnt_d   = CNT_RELOAD;
                  end
               end else if (load_use) begin
                  stall_f_o  = 1'b1;
                  stall_d_o  = 1'b1;
                  bubble_e_o = 1'b1;
               end
            end
         end

         ST_FLUSH: begin
            if (mem_busy_i) begin
               // Freeze wins; the outstanding flush slots are abandoned and
               // any redirect seen now is replayed once memory is free.
               {stall_f_o, stall_d_o, stall_e_o, stall_m_o} = 4'b1111;
               pend_d  = redirect_i;
               cnt_d   = 3'd0;
               state_d = ST_MEM_WAIT;
            end else if (redirect_i) begin
               flush_d_o  = 1'b1;
               bubble_e_o = 1'b1;
               redir_take = 1'b1;
               cnt_d      = CNT_RELOAD;
            end else begin
               flush_d_o = 1'b1;
               cnt_d     = cnt_q - 3'd1;
               if (cnt_q == 3'd1)
                  state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
            pend_d  = 1'b0;
         end
      endcase

      // Reset squashes decode and execute and drops every stall.
      if (rst_i) begin
         stall_f_o  = 1'b0;
         stall_d_o  = 1'b0;
         stall_e_o  = 1'b0;
         stall_m_o  = 1'b0;
         bubble_e_o = 1'b1;
         flush_d_o  = 1'b1;
         redir_take = 1'b0;
      end
   end

   // State register, flush down-counter, deferred redirect and perf counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         cnt_q       <= 3'd0;
         pend_q      <= 1'b0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         if (stall_f_o && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (redir_take && !(&redir_cnt_q))
            redir_cnt_q <= redir_cnt_q + 1'b1;
      end
   end

   assign state_o          = state_q;
   assign stall_cycles_o   = stall_cnt_q;
   assign redirect_count_o = redir_cnt_q;

endmodule
`default_nettype wire
